// File: rtl/pe_acc_array.sv
// pe_acc_array: registered signed adder tree summing N_IN lanes per beat, feeding a saturating
// per-frame accumulator with a DATA_W-clamped result. Build macro PE_RELU_EN zeroes negative results.
module pe_acc_array #(
    parameter int N_IN      = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_vld,
    input  logic                     i_last,
    input  logic [N_IN*DATA_W-1:0]   in_flat,
    output logic [DATA_W-1:0]        out_node,
    output logic                     o_vld,
    output logic                     o_sat
);
    localparam int D      = $clog2(N_IN);
    localparam int N_PAD  = 1 << D;
    localparam int TREE_W = DATA_W + D;
    localparam int ACC_W  = DATA_W + D + $clog2(MAX_BEATS) + 1;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic signed [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Lanes are widened to the final tree width up front; padding lanes contribute zero.
    logic [N_PAD*TREE_W-1:0] lanes_ext;

    genvar k;
    generate
        for (k = 0; k < N_PAD; k++) begin : g_lane
            if (k < N_IN) begin : g_real
                assign lanes_ext[k*TREE_W +: TREE_W] = TREE_W'($signed(in_flat[k*DATA_W +: DATA_W]));
            end else begin : g_pad
                assign lanes_ext[k*TREE_W +: TREE_W] = '0;
            end
        end
    endgenerate

    // Level 0 registers the input beat; each following level halves the operand count.
    genvar s;
    generate
        for (s = 0; s <= D; s++) begin : g_lvl
            localparam int CNT = N_PAD >> s;
            logic [CNT*TREE_W-1:0] sum;
            logic                  vld;
            logic                  last;

            if (s == 0) begin : g_in
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sum  <= '0;
                        vld  <= 1'b0;
                        last <= 1'b0;
                    end else begin
                        vld  <= i_vld;
                        last <= i_vld & i_last;
                        if (i_vld) begin
                            sum <= lanes_ext;
                        end
                    end
                end
            end else begin : g_add
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sum  <= '0;
                        vld  <= 1'b0;
                        last <= 1'b0;
                    end else begin
                        vld  <= g_lvl[s-1].vld;
                        last <= g_lvl[s-1].last;
                        if (g_lvl[s-1].vld) begin
                            for (int j = 0; j < CNT; j++) begin
                                sum[j*TREE_W +: TREE_W] <=
                                    $signed(g_lvl[s-1].sum[(2*j)*TREE_W +: TREE_W]) +
                                    $signed(g_lvl[s-1].sum[(2*j+1)*TREE_W +: TREE_W]);
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    logic signed [TREE_W-1:0] beat_sum;
    logic                     tree_vld;
    logic                     tree_last;

    assign beat_sum  = $signed(g_lvl[D].sum);
    assign tree_vld  = g_lvl[D].vld;
    assign tree_last = g_lvl[D].last;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [SUM_W-1:0]  acc_wide;
    logic                     acc_clamp;
    logic                     sticky;
    logic signed [DATA_W-1:0] frame_val;
    logic                     data_clamp;

    always_comb begin
        acc_wide  = SUM_W'(acc) + SUM_W'(beat_sum);
        acc_next  = acc_wide[ACC_W-1:0];
        acc_clamp = 1'b0;
        if (acc_wide > SUM_W'(ACC_MAX)) begin
            acc_next  = ACC_MAX;
            acc_clamp = 1'b1;
        end else if (acc_wide < SUM_W'(ACC_MIN)) begin
            acc_next  = ACC_MIN;
            acc_clamp = 1'b1;
        end
    end

    always_comb begin
        frame_val  = acc_next[DATA_W-1:0];
        data_clamp = 1'b0;
        if (acc_next > ACC_W'(DATA_MAX)) begin
            frame_val  = DATA_MAX;
            data_clamp = 1'b1;
        end else if (acc_next < ACC_W'(DATA_MIN)) begin
            frame_val  = DATA_MIN;
            data_clamp = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            sticky   <= 1'b0;
            out_node <= '0;
            o_vld    <= 1'b0;
            o_sat    <= 1'b0;
        end else begin
            o_vld <= 1'b0;
            if (tree_vld) begin
                if (tree_last) begin
`ifdef PE_RELU_EN
                    out_node <= frame_val[DATA_W-1] ? '0 : frame_val;
`else
                    out_node <= frame_val;
`endif
                    o_vld  <= 1'b1;
                    o_sat  <= sticky | acc_clamp | data_clamp;
                    acc    <= '0;
                    sticky <= 1'b0;
                end else begin
                    acc    <= acc_next;
                    sticky <= sticky | acc_clamp;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_acc_array.sv
// Self-checking bench for pe_acc_array: expected frame results are queued when the last beat
// is driven and compared (value, saturation, arrival edge) when o_vld appears.
module tb_pe_acc_array;
    localparam int N_IN      = 8;
    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 16;
    localparam int LAT       = 4;
`ifdef PE_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   i_vld;
    logic                   i_last;
    logic [N_IN*DATA_W-1:0] in_flat;
    logic [DATA_W-1:0]      out_node;
    logic                   o_vld;
    logic                   o_sat;

    typedef struct {
        logic [31:0] out;
        logic        sat;
        int          edge_n;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    pe_acc_array #(.N_IN(N_IN), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst(rst), .i_vld(i_vld), .i_last(i_last), .in_flat(in_flat),
        .out_node(out_node), .o_vld(o_vld), .o_sat(o_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(input longint sum, input int edge_n);
        exp_t   r;
        longint v = sum;
        r.sat = 1'b0;
        if (v > 64'sd2147483647) begin
            v = 64'sd2147483647;
            r.sat = 1'b1;
        end else if (v < -64'sd2147483648) begin
            v = -64'sd2147483648;
            r.sat = 1'b1;
        end
        if (RELU && v < 0) v = 0;
        r.out    = v[31:0];
        r.edge_n = edge_n;
        return r;
    endfunction

    function automatic logic [N_IN*DATA_W-1:0] fill(input logic [31:0] val);
        logic [N_IN*DATA_W-1:0] f;
        for (int i = 0; i < N_IN; i++) f[i*DATA_W +: DATA_W] = val;
        return f;
    endfunction

    task automatic drive_beat(input logic vld, input logic last, input logic [N_IN*DATA_W-1:0] flat);
        @(negedge clk);
        i_vld   = vld;
        i_last  = last;
        in_flat = flat;
    endtask

    task automatic drive_idle();
        drive_beat(1'b0, 1'b0, '0);
    endtask

    // Waits up to budget edges for an o_vld pulse and reports what was seen.
    task automatic collect(input int budget, output logic got, output logic [31:0] out,
                           output logic sat, output int e);
        got = 1'b0; out = '0; sat = 1'b0; e = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            if (o_vld === 1'b1) begin
                got = 1'b1; out = out_node; sat = o_sat; e = cyc;
            end
        end
    endtask

    task automatic test_reset();
        logic got; logic [31:0] out; logic sat; int e;
        rst = 1'b1; i_vld = 1'b1; i_last = 1'b1; in_flat = fill(32'd1);
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (out_node !== 32'd0) begin n_err++; $display("FAIL reset_out got=%h exp=0", out_node); end
        n_vec++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got=%b exp=0", o_vld); end
        n_vec++; if (o_sat !== 1'b0) begin n_err++; $display("FAIL reset_sat got=%b exp=0", o_sat); end
        @(negedge clk);
        rst = 1'b0; i_vld = 1'b0; i_last = 1'b0; in_flat = '0;
        collect(10, got, out, sat, e);
        n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL reset_discard got o_vld at edge %0d exp none", e); end
    endtask

    task automatic test_single();
        logic got; logic [31:0] out; logic sat; int e; exp_t x;
        drive_beat(1'b1, 1'b1, fill(32'd1));
        sb.push_back(model(64'sd8, cyc + 1 + LAT));
        drive_idle();
        collect(12, got, out, sat, e);
        x = sb.pop_front();
        n_vec++;
        if (!got || out !== x.out || sat !== x.sat || e != x.edge_n) begin
            n_err++; $display("FAIL single got=%b out=%h sat=%b edge=%0d exp out=%h sat=%b edge=%0d", got, out, sat, e, x.out, x.sat, x.edge_n);
        end
        collect(6, got, out, sat, e);
        n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL single_extra got o_vld at edge %0d exp none", e); end
        n_vec++; if (out_node !== 32'd8) begin n_err++; $display("FAIL single_hold got=%h exp=00000008", out_node); end
    endtask

    task automatic test_back_to_back();
        logic got; logic [31:0] out; logic sat; int e; exp_t x;
        drive_beat(1'b1, 1'b0, fill(32'd2));
        drive_beat(1'b1, 1'b0, fill(32'd2));
        drive_beat(1'b1, 1'b1, fill(32'd2));
        sb.push_back(model(64'sd48, cyc + 1 + LAT));
        drive_beat(1'b1, 1'b1, fill(32'd1));
        sb.push_back(model(64'sd8, cyc + 1 + LAT));
        drive_idle();
        for (int f = 0; f < 2; f++) begin
            collect(12, got, out, sat, e);
            x = sb.pop_front();
            n_vec++;
            if (!got || out !== x.out || sat !== x.sat || e != x.edge_n) begin
                n_err++; $display("FAIL b2b_%0d got=%b out=%h sat=%b edge=%0d exp out=%h sat=%b edge=%0d", f, got, out, sat, e, x.out, x.sat, x.edge_n);
            end
        end
        collect(6, got, out, sat, e);
        n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL b2b_extra got o_vld at edge %0d exp none", e); end
    endtask

    task automatic test_saturation();
        logic got; logic [31:0] out; logic sat; int e; exp_t x;
        logic [31:0] vals [3];
        vals[0] = 32'h7FFF_FFFF; vals[1] = 32'h8000_0000; vals[2] = 32'hFFFF_FFFF;
        for (int f = 0; f < 3; f++) begin
            drive_beat(1'b1, 1'b1, fill(vals[f]));
            sb.push_back(model(longint'(N_IN) * longint'($signed(vals[f])), cyc + 1 + LAT));
        end
        drive_idle();
        for (int f = 0; f < 3; f++) begin
            collect(12, got, out, sat, e);
            x = sb.pop_front();
            n_vec++;
            if (!got || out !== x.out || sat !== x.sat || e != x.edge_n) begin
                n_err++; $display("FAIL sat_%0d got=%b out=%h sat=%b edge=%0d exp out=%h sat=%b edge=%0d", f, got, out, sat, e, x.out, x.sat, x.edge_n);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic got; logic [31:0] out; logic sat; int e; exp_t x;
        drive_beat(1'b1, 1'b1, fill(32'd1));
        drive_beat(1'b0, 1'b0, '0);
        rst = 1'b1;
        drive_beat(1'b0, 1'b0, '0);
        rst = 1'b0;
        collect(8, got, out, sat, e);
        n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL abort_pipe got o_vld at edge %0d exp none", e); end
        drive_beat(1'b1, 1'b0, fill(32'd1));
        drive_beat(1'b1, 1'b0, fill(32'd1));
        drive_beat(1'b1, 1'b1, fill(32'd5));
        rst = 1'b1;
        drive_beat(1'b1, 1'b1, fill(32'd1));
        rst = 1'b0;
        sb.push_back(model(64'sd8, cyc + 1 + LAT));
        drive_idle();
        collect(12, got, out, sat, e);
        x = sb.pop_front();
        n_vec++;
        if (!got || out !== x.out || sat !== x.sat || e != x.edge_n) begin
            n_err++; $display("FAIL reset_mid got=%b out=%h sat=%b edge=%0d exp out=%h sat=%b edge=%0d", got, out, sat, e, x.out, x.sat, x.edge_n);
        end
        collect(6, got, out, sat, e);
        n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL reset_mid_extra got o_vld at edge %0d exp none", e); end
    endtask

    task automatic test_bubbles();
        logic got; logic [31:0] out; logic sat; int e; exp_t x;
        drive_beat(1'b1, 1'b0, fill(32'd3));
        drive_beat(1'b0, 1'b0, '0);
        drive_beat(1'b1, 1'b0, fill(32'd3));
        drive_beat(1'b0, 1'b1, fill(32'd7));
        drive_beat(1'b1, 1'b0, fill(32'd3));
        drive_beat(1'b0, 1'b0, '0);
        drive_beat(1'b1, 1'b1, fill(32'd3));
        sb.push_back(model(64'sd96, cyc + 1 + LAT));
        drive_idle();
        collect(12, got, out, sat, e);
        x = sb.pop_front();
        n_vec++;
        if (!got || out !== x.out || sat !== x.sat || e != x.edge_n) begin
            n_err++; $display("FAIL bubbles got=%b out=%h sat=%b edge=%0d exp out=%h sat=%b edge=%0d", got, out, sat, e, x.out, x.sat, x.edge_n);
        end
        collect(6, got, out, sat, e);
        n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL bubbles_extra got o_vld at edge %0d exp none", e); end
    endtask

    task automatic test_random();
        logic got; logic [31:0] out; logic sat; int e; exp_t x;
        logic [N_IN*DATA_W-1:0] flat;
        longint sum;
        int len;
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 4);
            sum = 0;
            for (int b = 0; b < len; b++) begin
                for (int l = 0; l < N_IN; l++) begin
                    flat[l*DATA_W +: DATA_W] = $urandom();
                    sum += longint'($signed(flat[l*DATA_W +: DATA_W]));
                end
                drive_beat(1'b1, b == len - 1, flat);
                if (b == len - 1) sb.push_back(model(sum, cyc + 1 + LAT));
                if (b != len - 1 && $urandom_range(0, 1) == 1) drive_beat(1'b0, 1'b1, '1);
            end
            drive_idle();
            collect(12, got, out, sat, e);
            x = sb.pop_front();
            n_vec++;
            if (!got || out !== x.out || sat !== x.sat || e != x.edge_n) begin
                n_err++; $display("FAIL random_%0d got=%b out=%h sat=%b edge=%0d exp out=%h sat=%b edge=%0d", f, got, out, sat, e, x.out, x.sat, x.edge_n);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_vld = 1'b0; i_last = 1'b0; in_flat = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_bubbles();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
